// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU: opcode encoding, handshake
// FSM states and the divide-by-zero result pattern.
package alu_pkg;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        MUL  = 4'd2,
        DIV  = 4'd3,
        SHL  = 4'd4,
        SHR  = 4'd5,
        ROL  = 4'd6,
        ROR  = 4'd7,
        AND  = 4'd8,
        OR   = 4'd9,
        XOR  = 4'd10,
        NOR  = 4'd11,
        NAND = 4'd12,
        XNOR = 4'd13,
        GT   = 4'd14,
        EQ   = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } alu_state_e;

    // Wide enough for any supported WIDTH; users slice the low WIDTH bits.
    localparam logic [63:0] DIV_BY_ZERO_RESULT = '1;

endpackage

// File: rtl/alu_divider.sv
// Serial restoring divider: operands latched on start, one quotient bit per clock.
// done is a one-cycle pulse in the cycle the final bit resolves, with quotient valid.
module alu_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_step, quo_step;

    always_comb begin
        // Negative trial (MSB set) means the divisor did not fit: restore.
        trial    = {rem_q, quo_q[WIDTH-1]} - {1'b0, div_q};
        rem_step = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
        quo_step = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

        rem_d  = rem_q;
        quo_d  = quo_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start) begin
            rem_d  = '0;
            quo_d  = dividend;
            div_d  = divisor;
            cnt_d  = CNT_W'(WIDTH);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign done     = busy_q & (cnt_q == CNT_W'(1));
    assign quotient = quo_step;

endmodule

// File: rtl/alu_seq_core.sv
// Sequential ALU with valid/ready handshake: single-cycle ops resolve on the accept
// edge, divide runs on the serial divider; results are held until consumed.
module alu_seq_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_Sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             CarryOut,
    output logic             div_by_zero
);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             dbz_q, dbz_d;
    alu_op_e          op_in;
    logic             accept, div_start, div_done;
    logic [WIDTH-1:0] div_quotient;
    logic [WIDTH:0]   comb_result;

    function automatic logic [WIDTH:0] alu_compute(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input alu_op_e op);
        logic [WIDTH:0]     sum;
        logic [2*WIDTH-1:0] prod;
        logic [WIDTH-1:0]   res;
        logic               cy;
        sum  = {1'b0, a} + {1'b0, b};
        prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        res  = '0;
        cy   = 1'b0;
        case (op)
            ADD:  begin res = sum[WIDTH-1:0]; cy = sum[WIDTH]; end
            SUB:  begin res = a - b; cy = (a < b); end
            MUL:  begin res = prod[WIDTH-1:0]; cy = |prod[2*WIDTH-1:WIDTH]; end
            DIV:  res = DIV_BY_ZERO_RESULT[WIDTH-1:0];
            SHL:  begin res = {a[WIDTH-2:0], 1'b0}; cy = a[WIDTH-1]; end
            SHR:  begin res = {1'b0, a[WIDTH-1:1]}; cy = a[0]; end
            ROL:  res = {a[WIDTH-2:0], a[WIDTH-1]};
            ROR:  res = {a[0], a[WIDTH-1:1]};
            AND:  res = a & b;
            OR:   res = a | b;
            XOR:  res = a ^ b;
            NOR:  res = ~(a | b);
            NAND: res = ~(a & b);
            XNOR: res = ~(a ^ b);
            GT:   res = {{(WIDTH-1){1'b0}}, (a > b)};
            EQ:   res = {{(WIDTH-1){1'b0}}, (a == b)};
            default: res = '0;
        endcase
        return {cy, res};
    endfunction

    assign op_in       = alu_op_e'(ALU_Sel);
    assign accept      = in_valid & in_ready;
    assign div_start   = accept & (op_in == DIV) & (|B);
    assign comb_result = alu_compute(A, B, op_in);

    alu_divider #(.WIDTH(WIDTH)) u_div (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start),
        .dividend (A),
        .divisor  (B),
        .done     (div_done),
        .quotient (div_quotient)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            carry_q <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = div_start ? S_DIV : S_DONE;
            S_DIV:   if (div_done) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = accept ? (div_start ? S_DIV : S_DONE) : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Result registers only move on a new single-cycle accept or divider completion,
    // so a stalled result stays stable under backpressure.
    always_comb begin
        res_d   = res_q;
        carry_d = carry_q;
        dbz_d   = dbz_q;
        if (accept && !div_start) begin
            res_d   = comb_result[WIDTH-1:0];
            carry_d = comb_result[WIDTH];
            dbz_d   = (op_in == DIV);
        end else if (state_q == S_DIV && div_done) begin
            res_d   = div_quotient;
            carry_d = 1'b0;
            dbz_d   = 1'b0;
        end
    end

    always_comb begin
        in_ready  = reset & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
        out_valid = (state_q == S_DONE);
    end

    assign ALU_Out     = res_q;
    assign CarryOut    = carry_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core: opcode vector table plus backpressure and
// mid-divide reset sequences.
module tb_alu_seq_core;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] ALU_Sel;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] ALU_Out;
    logic       CarryOut;
    logic       div_by_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        logic [7:0] out;
        logic       c;
        logic       dbz;
        int         lat;
    } vec_t;

    vec_t vecs [24];

    alu_seq_core #(.WIDTH(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .A           (A),
        .B           (B),
        .ALU_Sel     (ALU_Sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ALU_Out     (ALU_Out),
        .CarryOut    (CarryOut),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) check({name, "_ready_wait"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input vec_t v, input string nm);
        int lat;
        int low;
        @(negedge clock);
        wait_ready(nm);
        in_valid = 1'b1;
        A        = v.a;
        B        = v.b;
        ALU_Sel  = v.sel;
        @(posedge clock);
        lat = 1;
        #1;
        in_valid = 1'b0;
        A        = 8'($urandom);
        B        = 8'($urandom);
        ALU_Sel  = 4'($urandom);
        low = 0;
        @(negedge clock);
        while (!out_valid && lat < 40) begin
            if (!in_ready) low++;
            @(negedge clock);
            lat++;
        end
        check({nm, "_lat"}, 32'(lat), 32'(v.lat));
        check({nm, "_busy_cycles"}, 32'(low), 32'(v.lat - 1));
        check({nm, "_out"}, 32'(ALU_Out), 32'(v.out));
        check({nm, "_carry"}, 32'(CarryOut), 32'(v.c));
        check({nm, "_dbz"}, 32'(div_by_zero), 32'(v.dbz));
    endtask

    initial begin
        vecs[0]  = '{8'd200, 8'd100, 4'd0,  8'd44,  1'b1, 1'b0, 1};
        vecs[1]  = '{8'd5,   8'd10,  4'd1,  8'hFB,  1'b1, 1'b0, 1};
        vecs[2]  = '{8'd16,  8'd17,  4'd2,  8'h10,  1'b1, 1'b0, 1};
        vecs[3]  = '{8'd100, 8'd7,   4'd3,  8'd14,  1'b0, 1'b0, 9};
        vecs[4]  = '{8'd55,  8'd0,   4'd3,  8'hFF,  1'b0, 1'b1, 1};
        vecs[5]  = '{8'd3,   8'd4,   4'd0,  8'd7,   1'b0, 1'b0, 1};
        vecs[6]  = '{8'h81,  8'h00,  4'd4,  8'h02,  1'b1, 1'b0, 1};
        vecs[7]  = '{8'h81,  8'h00,  4'd5,  8'h40,  1'b1, 1'b0, 1};
        vecs[8]  = '{8'h81,  8'h00,  4'd6,  8'h03,  1'b0, 1'b0, 1};
        vecs[9]  = '{8'h81,  8'h00,  4'd7,  8'hC0,  1'b0, 1'b0, 1};
        vecs[10] = '{8'hF0,  8'h3C,  4'd8,  8'h30,  1'b0, 1'b0, 1};
        vecs[11] = '{8'hF0,  8'h3C,  4'd9,  8'hFC,  1'b0, 1'b0, 1};
        vecs[12] = '{8'hF0,  8'h3C,  4'd10, 8'hCC,  1'b0, 1'b0, 1};
        vecs[13] = '{8'hF0,  8'h3C,  4'd11, 8'h03,  1'b0, 1'b0, 1};
        vecs[14] = '{8'hF0,  8'h3C,  4'd12, 8'hCF,  1'b0, 1'b0, 1};
        vecs[15] = '{8'hF0,  8'h3C,  4'd13, 8'h33,  1'b0, 1'b0, 1};
        vecs[16] = '{8'd9,   8'd3,   4'd14, 8'd1,   1'b0, 1'b0, 1};
        vecs[17] = '{8'd3,   8'd9,   4'd14, 8'd0,   1'b0, 1'b0, 1};
        vecs[18] = '{8'd9,   8'd9,   4'd15, 8'd1,   1'b0, 1'b0, 1};
        vecs[19] = '{8'd9,   8'd8,   4'd15, 8'd0,   1'b0, 1'b0, 1};
        vecs[20] = '{8'd255, 8'd1,   4'd3,  8'd255, 1'b0, 1'b0, 9};
        vecs[21] = '{8'd7,   8'd200, 4'd3,  8'd0,   1'b0, 1'b0, 9};
        vecs[22] = '{8'd10,  8'd5,   4'd1,  8'd5,   1'b0, 1'b0, 1};
        vecs[23] = '{8'd15,  8'd15,  4'd2,  8'hE1,  1'b0, 1'b0, 1};

        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        ALU_Sel   = '0;
        repeat (3) @(negedge clock);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_alu_out", 32'(ALU_Out), 32'd0);
        check("rst_carry", 32'(CarryOut), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 24; i++) begin
            run_op(vecs[i], $sformatf("v%0d", i));
        end

        // Backpressure: eq(9,9) stalls 5 cycles while a new add request waits.
        @(negedge clock);
        wait_ready("bp");
        out_ready = 1'b0;
        in_valid  = 1'b1;
        A         = 8'd9;
        B         = 8'd9;
        ALU_Sel   = 4'd15;
        @(posedge clock);
        #1;
        A       = 8'd1;
        B       = 8'd2;
        ALU_Sel = 4'd0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check($sformatf("bp%0d_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d_out", k), 32'(ALU_Out), 32'd1);
            check($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(negedge clock);
        check("bp_b2b_valid", 32'(out_valid), 32'd1);
        check("bp_b2b_out", 32'(ALU_Out), 32'd3);
        check("bp_b2b_carry", 32'(CarryOut), 32'd0);

        // Reset in the middle of a divide.
        @(negedge clock);
        wait_ready("rdiv");
        in_valid = 1'b1;
        A        = 8'd100;
        B        = 8'd7;
        ALU_Sel  = 4'd3;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("rdiv_out_valid", 32'(out_valid), 32'd0);
        check("rdiv_in_ready", 32'(in_ready), 32'd0);
        check("rdiv_alu_out", 32'(ALU_Out), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        check("rdiv_release_in_ready", 32'(in_ready), 32'd1);
        begin
            int stale;
            stale = 0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clock);
                if (out_valid) stale++;
            end
            check("rdiv_no_stale", 32'(stale), 32'd0);
        end
        run_op('{8'd1, 8'd1, 4'd0, 8'd2, 1'b0, 1'b0, 1}, "post_rdiv");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
